fsm: RTL and testbench



---
 rtl/fsm.sv | 95 +++++++++
 tb/tb_fsm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// Control block for the 8x8 toroidal Game of Life core: grid, free-running LFSR,
// run/random control FSM and the registered HDMI frame.
module fsm (
  input  logic        clk,
  input  logic        resetG,
  input  logic        resetL,
  input  logic        run,
  input  logic        rundom,
  input  logic        display,
  input  logic [63:0] seed,
  output logic [63:0] hdmi
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRand
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] grid_q, grid_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic [63:0] hdmi_q, hdmi_d;
  logic [63:0] life_next;
  logic        lfsr_fb;

  // One generation of the toroidal grid; neighbour indices wrap mod 8 in both axes.
  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      localparam int Rm = (r + 7) % 8;
      localparam int Rp = (r + 1) % 8;
      localparam int Cm = (c + 7) % 8;
      localparam int Cp = (c + 1) % 8;
      logic [3:0] n;
      assign n = 4'(grid_q[Rm*8+Cm]) + 4'(grid_q[Rm*8+c]) + 4'(grid_q[Rm*8+Cp])
               + 4'(grid_q[r*8+Cm])                        + 4'(grid_q[r*8+Cp])
               + 4'(grid_q[Rp*8+Cm]) + 4'(grid_q[Rp*8+c]) + 4'(grid_q[Rp*8+Cp]);
      assign life_next[r*8+c] = (n == 4'd3) | (grid_q[r*8+c] & (n == 4'd2));
    end
  end

  assign lfsr_fb = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rundom)   state_d = StRand;
        else if (run) state_d = StRun;
      end
      StRun: begin
        if (rundom)    state_d = StRand;
        else if (!run) state_d = StIdle;
      end
      StRand: begin
        if (!rundom) state_d = run ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (resetL) state_d = StIdle;
  end

  always_comb begin
    grid_d = grid_q;
    lfsr_d = {lfsr_q[62:0], lfsr_fb};
    hdmi_d = display ? lfsr_q : grid_q;
    unique case (state_q)
      StRun:   grid_d = life_next;
      StRand:  grid_d = lfsr_q;
      default: grid_d = grid_q;
    endcase
    // Seed load overrides the grid/LFSR update but leaves the frame path alone.
    if (resetL) begin
      grid_d = seed;
      lfsr_d = seed;
    end
  end

  always_ff @(posedge clk or negedge resetG) begin
    if (!resetG) begin
      state_q <= StIdle;
      grid_q  <= 64'h0;
      lfsr_q  <= 64'h1;
      hdmi_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      lfsr_q  <= lfsr_d;
      hdmi_q  <= hdmi_d;
    end
  end

  assign hdmi = hdmi_q;

endmodule

// File: tb/tb_fsm.sv
// Directed bench for fsm: reset, blinker, wrapped block, LFSR steps, random fill,
// load priority and asynchronous reset, all observed on hdmi.
module tb_fsm;

  logic        clk = 1'b0;
  logic        resetG, resetL, run, rundom, display;
  logic [63:0] seed;
  logic [63:0] hdmi;

  int n_vec = 0;
  int n_err = 0;

  fsm u_dut (
    .clk    (clk),
    .resetG (resetG),
    .resetL (resetL),
    .run    (run),
    .rundom (rundom),
    .display(display),
    .seed   (seed),
    .hdmi   (hdmi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  function automatic logic [63:0] life_model(input logic [63:0] g);
    logic [63:0] nxt;
    int n;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) n += int'(g[((r + dr + 8) % 8) * 8 + (c + dc + 8) % 8]);
          end
        end
        nxt[r*8+c] = (n == 3) || (g[r*8+c] && n == 2);
      end
    end
    return nxt;
  endfunction

  logic [63:0] s, s1, s2, s3, l3;

  initial begin
    resetG = 1'b0; resetL = 1'b0; run = 1'b0; rundom = 1'b0; display = 1'b0; seed = '0;
    #2;
    check_eq("reset_hdmi", hdmi, 64'h0);
    #10 resetG = 1'b1;
    display = 1'b1;
    tick(); check_eq("lfsr_first", hdmi, 64'h1);
    tick(); check_eq("lfsr_second", hdmi, 64'h2);
    display = 1'b0;
    tick(); check_eq("grid_zero", hdmi, 64'h0);

    // Blinker
    resetL = 1'b1; seed = 64'h700;
    tick();
    resetL = 1'b0; run = 1'b1;
    tick(); check_eq("blink_k", hdmi, 64'h700);
    tick(); check_eq("blink_k1", hdmi, 64'h700);
    tick(); check_eq("blink_k2", hdmi, 64'h20202);
    tick(); check_eq("blink_k3", hdmi, 64'h700);
    tick(); check_eq("blink_k4", hdmi, 64'h20202);
    tick(); check_eq("blink_k5", hdmi, 64'h700);

    // Block wrapped across all four corners
    run = 1'b0; resetL = 1'b1; seed = 64'h8100_0000_0000_0081;
    tick();
    resetL = 1'b0; run = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick(); check_eq($sformatf("wrap_%0d", i), hdmi, 64'h8100_0000_0000_0081);
    end

    // LFSR steps from loaded seeds
    run = 1'b0; display = 1'b1; resetL = 1'b1; seed = 64'h8000_0000_0000_0000;
    tick();
    resetL = 1'b0;
    tick(); check_eq("lfsr_msb_seed", hdmi, 64'h8000_0000_0000_0000);
    tick(); check_eq("lfsr_msb_next", hdmi, 64'h1);
    resetL = 1'b1; seed = 64'h1;
    tick();
    resetL = 1'b0;
    tick(); check_eq("lfsr_one_seed", hdmi, 64'h1);
    tick(); check_eq("lfsr_one_next", hdmi, 64'h2);

    // Random fill with run held high; RAND must win, then fall back to RUN
    display = 1'b0; resetL = 1'b1; s = 64'h4206_9960_2400_0700; seed = s;
    tick();
    s1 = lfsr_step(s); s2 = lfsr_step(s1); s3 = lfsr_step(s2); l3 = life_model(s3);
    resetL = 1'b0; run = 1'b1; rundom = 1'b1;
    tick(); check_eq("rand_k", hdmi, s);
    tick(); check_eq("rand_k1", hdmi, s);
    tick(); check_eq("rand_k2", hdmi, s1);
    rundom = 1'b0;
    tick(); check_eq("rand_k3", hdmi, s2);
    tick(); check_eq("rand_k4", hdmi, s3);
    tick(); check_eq("rand_run1", hdmi, l3);
    tick(); check_eq("rand_run2", hdmi, life_model(l3));

    // Load beats simultaneous run and rundom
    resetL = 1'b1; rundom = 1'b1; run = 1'b1; seed = 64'h700;
    tick();
    resetL = 1'b0; rundom = 1'b0;
    tick(); check_eq("load_prio_k", hdmi, 64'h700);
    tick(); check_eq("load_prio_k1", hdmi, 64'h700);
    tick(); check_eq("load_prio_k2", hdmi, 64'h20202);

    // Asynchronous reset between edges while running
    #3 resetG = 1'b0;
    #1 check_eq("async_clear", hdmi, 64'h0);
    @(negedge clk);
    resetG = 1'b1; display = 1'b1;
    tick(); check_eq("post_reset_l1", hdmi, 64'h1);
    display = 1'b0;
    tick(); check_eq("post_reset_grid", hdmi, 64'h0);
    tick(); check_eq("post_reset_grid2", hdmi, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
